// File: rtl/rom_sink_resp.sv
// rtl/rom_sink_resp.sv - instruction-fetch responder with loadable program storage and fixed-latency delivery
// Optional ROM_PREFETCH_EN: next-word prefetch buffer giving one-cycle delivery on sequential fetches.
module rom_sink_resp #(
  parameter int LARGURA_END = 8,
  parameter int PALAVRAS    = 256,
  parameter int LATENCIA    = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   Rom_sink_cen,
  input  logic                   Rom_sink_ren,
  input  logic [LARGURA_END-1:0] endereco,
  input  logic                   carga_en,
  input  logic [LARGURA_END-1:0] carga_end,
  input  logic [15:0]            carga_dado,
  output logic [15:0]            instrucao,
  output logic                   instr_valida,
  output logic                   ocupado,
  output logic                   erro_endereco,
  output logic                   pedido_perdido
);

  localparam logic [LARGURA_END:0] PALAVRAS_W = (LARGURA_END+1)'(PALAVRAS);
  localparam logic [3:0]           LAT_M1     = 4'(LATENCIA - 1);

  typedef enum logic [1:0] {OCIOSO, ESPERA, ENTREGA} estado_t;

  estado_t     estado, estado_prox;
  logic [3:0]  cont, cont_prox;
  logic [15:0] mem [PALAVRAS];
  logic [15:0] retido;
  logic        erro_retido;
  logic        pedido, aceita, entrega, end_ok, carga_ok, acerto;
  logic [15:0] dado_lido;

  assign pedido   = Rom_sink_cen & Rom_sink_ren;
  assign end_ok   = {1'b0, endereco} < PALAVRAS_W;
  assign carga_ok = carga_en && ({1'b0, carga_end} < PALAVRAS_W);

`ifdef ROM_PREFETCH_EN
  logic                   pf_valido, pf_ativo;
  logic [3:0]             pf_cont;
  logic [LARGURA_END-1:0] pf_tag, tag_alvo, end_retido;
  logic [15:0]            pf_dado;
  logic [LARGURA_END:0]   end_seg;
  logic                   pf_inicia;

  assign acerto    = pf_valido && (pf_tag == endereco);
  assign end_seg   = {1'b0, end_retido} + 1'b1;
  assign pf_inicia = entrega && !erro_retido && (end_seg < PALAVRAS_W);
  assign tag_alvo  = pf_inicia ? end_seg[LARGURA_END-1:0] : pf_tag;
  assign dado_lido = acerto ? pf_dado : (end_ok ? mem[endereco] : 16'h0000);

  // Any accepted request consumes or discards the buffer; a load to the tag always kills it.
  always_ff @(posedge clock) begin
    if (!reset) begin
      pf_valido  <= 1'b0;
      pf_ativo   <= 1'b0;
      pf_cont    <= 4'd0;
      pf_tag     <= '0;
      pf_dado    <= 16'h0000;
      end_retido <= '0;
    end else begin
      if (aceita) end_retido <= endereco;
      if (pf_inicia) begin
        pf_ativo  <= 1'b1;
        pf_valido <= 1'b0;
        pf_tag    <= end_seg[LARGURA_END-1:0];
        pf_cont   <= 4'(LATENCIA);
      end else if (aceita) begin
        pf_ativo  <= 1'b0;
        pf_valido <= 1'b0;
      end else if (pf_ativo) begin
        if (pf_cont == 4'd1) begin
          pf_ativo  <= 1'b0;
          pf_valido <= 1'b1;
          pf_dado   <= mem[pf_tag];
        end else begin
          pf_cont <= pf_cont - 4'd1;
        end
      end
      if (carga_ok && (carga_end == tag_alvo)) begin
        pf_valido <= 1'b0;
        pf_ativo  <= 1'b0;
      end
    end
  end
`else
  assign acerto    = 1'b0;
  assign dado_lido = end_ok ? mem[endereco] : 16'h0000;
`endif

  always_comb begin
    estado_prox = estado;
    cont_prox   = cont;
    aceita      = 1'b0;
    entrega     = 1'b0;
    case (estado)
      OCIOSO: begin
        if (pedido) begin
          aceita    = 1'b1;
          cont_prox = LAT_M1;
          if (acerto || (LATENCIA == 1)) estado_prox = ENTREGA;
          else                           estado_prox = ESPERA;
        end
      end
      ESPERA: begin
        if (cont == 4'd1) estado_prox = ENTREGA;
        else              cont_prox   = cont - 4'd1;
      end
      ENTREGA: begin
        entrega     = 1'b1;
        estado_prox = OCIOSO;
      end
      default: estado_prox = OCIOSO;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      estado         <= OCIOSO;
      cont           <= 4'd0;
      retido         <= 16'h0000;
      erro_retido    <= 1'b0;
      instrucao      <= 16'h0000;
      instr_valida   <= 1'b0;
      ocupado        <= 1'b0;
      erro_endereco  <= 1'b0;
      pedido_perdido <= 1'b0;
    end else begin
      estado        <= estado_prox;
      cont          <= cont_prox;
      instr_valida  <= entrega;
      erro_endereco <= entrega & erro_retido;
      ocupado       <= (estado_prox == ESPERA);
      if (entrega) instrucao <= retido;
      if (pedido && (estado != OCIOSO)) pedido_perdido <= 1'b1;
      // Read-first: a same-edge load is not seen by this capture.
      if (aceita) begin
        retido      <= dado_lido;
        erro_retido <= !end_ok;
      end
    end
  end

  // Program image survives reset.
  always_ff @(posedge clock) begin
    if (carga_ok) mem[carga_end] <= carga_dado;
  end

endmodule

// File: tb/tb_rom_sink_resp.sv
// tb/tb_rom_sink_resp.sv - directed self-checking bench for rom_sink_resp (PALAVRAS=200, LATENCIA=2)
module tb_rom_sink_resp;

  logic        clock = 1'b0;
  logic        reset;
  logic        Rom_sink_cen, Rom_sink_ren;
  logic [7:0]  endereco;
  logic        carga_en;
  logic [7:0]  carga_end;
  logic [15:0] carga_dado;
  logic [15:0] instrucao;
  logic        instr_valida, ocupado, erro_endereco, pedido_perdido;

  int n_asserts = 0;
  int n_fail    = 0;

`ifdef ROM_PREFETCH_EN
  localparam int LAT_SEQ = 1;
`else
  localparam int LAT_SEQ = 2;
`endif

  rom_sink_resp #(.LARGURA_END(8), .PALAVRAS(200), .LATENCIA(2)) dut (
    .clock(clock), .reset(reset),
    .Rom_sink_cen(Rom_sink_cen), .Rom_sink_ren(Rom_sink_ren), .endereco(endereco),
    .carga_en(carga_en), .carga_end(carga_end), .carga_dado(carga_dado),
    .instrucao(instrucao), .instr_valida(instr_valida), .ocupado(ocupado),
    .erro_endereco(erro_endereco), .pedido_perdido(pedido_perdido)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [7:0] a, input logic [15:0] d);
    carga_en = 1'b1; carga_end = a; carga_dado = d;
    tick();
    carga_en = 1'b0;
  endtask

  task automatic fetch(input logic [7:0] a, input logic [15:0] exp_d, input logic exp_e,
                       input int exp_lat, input string tag);
    int n;
    Rom_sink_cen = 1'b1; Rom_sink_ren = 1'b1; endereco = a;
    tick();
    Rom_sink_cen = 1'b0; Rom_sink_ren = 1'b0;
    n = 0;
    while (!instr_valida && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_latency"}, 16'(n), 16'(exp_lat));
    chk({tag, "_instrucao"}, instrucao, exp_d);
    chk({tag, "_erro"}, 16'(erro_endereco), 16'(exp_e));
    tick();
    chk({tag, "_pulse_end"}, 16'(instr_valida), 16'h0);
  endtask

  initial begin
    reset = 1'b0; Rom_sink_cen = 1'b0; Rom_sink_ren = 1'b0; endereco = '0;
    carga_en = 1'b0; carga_end = '0; carga_dado = '0;
    tick(); tick();
    chk("rst_instrucao", instrucao, 16'h0000);
    chk("rst_valida", 16'(instr_valida), 16'h0);
    chk("rst_ocupado", 16'(ocupado), 16'h0);
    chk("rst_erro", 16'(erro_endereco), 16'h0);
    chk("rst_perdido", 16'(pedido_perdido), 16'h0);
    reset = 1'b1;

    load(8'd5, 16'h8A53);
    load(8'd3, 16'h3333);
    load(8'd7, 16'h1111);
    load(8'd10, 16'h0A0A);
    load(8'd11, 16'h0B0B);
    load(8'd20, 16'h1414);
    load(8'd210, 16'hDEAD);

    // Basic fetch with cycle-by-cycle view of ocupado
    Rom_sink_cen = 1'b1; Rom_sink_ren = 1'b1; endereco = 8'd5;
    tick();
    Rom_sink_cen = 1'b0; Rom_sink_ren = 1'b0;
    chk("f5_ocupado_c1", 16'(ocupado), 16'h1);
    chk("f5_valida_c1", 16'(instr_valida), 16'h0);
    tick();
    chk("f5_ocupado_c2", 16'(ocupado), 16'h0);
    chk("f5_valida_c2", 16'(instr_valida), 16'h0);
    tick();
    chk("f5_valida_c3", 16'(instr_valida), 16'h1);
    chk("f5_instrucao", instrucao, 16'h8A53);
    chk("f5_erro", 16'(erro_endereco), 16'h0);
    tick();
    chk("f5_valida_c4", 16'(instr_valida), 16'h0);
    chk("f5_hold", instrucao, 16'h8A53);

    // Out-of-range fetch; the dropped load to 210 must not appear either
    fetch(8'd220, 16'h0000, 1'b1, 2, "oor220");
    chk("oor220_perdido", 16'(pedido_perdido), 16'h0);
    fetch(8'd210, 16'h0000, 1'b1, 2, "oor210");

    // Single strobes while busy are not requests
    Rom_sink_cen = 1'b1; Rom_sink_ren = 1'b1; endereco = 8'd5;
    tick();
    Rom_sink_ren = 1'b0;
    tick();
    Rom_sink_cen = 1'b0; Rom_sink_ren = 1'b1;
    tick();
    Rom_sink_ren = 1'b0;
    chk("single_valida", 16'(instr_valida), 16'h1);
    chk("single_perdido", 16'(pedido_perdido), 16'h0);
    tick();

    // Request held for two cycles: second one is lost
    Rom_sink_cen = 1'b1; Rom_sink_ren = 1'b1; endereco = 8'd3;
    tick();
    tick();
    Rom_sink_cen = 1'b0; Rom_sink_ren = 1'b0;
    chk("lost_perdido", 16'(pedido_perdido), 16'h1);
    tick();
    chk("lost_valida", 16'(instr_valida), 16'h1);
    chk("lost_instrucao", instrucao, 16'h3333);
    tick(); tick(); tick();
    chk("lost_valida_once", 16'(instr_valida), 16'h0);
    chk("lost_sticky", 16'(pedido_perdido), 16'h1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("lost_cleared", 16'(pedido_perdido), 16'h0);

    // Same-edge load and fetch to 7: read-first
    Rom_sink_cen = 1'b1; Rom_sink_ren = 1'b1; endereco = 8'd7;
    carga_en = 1'b1; carga_end = 8'd7; carga_dado = 16'h2222;
    tick();
    Rom_sink_cen = 1'b0; Rom_sink_ren = 1'b0; carga_en = 1'b0;
    tick(); tick();
    chk("rf_valida", 16'(instr_valida), 16'h1);
    chk("rf_old_word", instrucao, 16'h1111);
    tick();
    fetch(8'd7, 16'h2222, 1'b0, 2, "rf_new");

    // Load during ESPERA does not alter in-flight word
    Rom_sink_cen = 1'b1; Rom_sink_ren = 1'b1; endereco = 8'd3;
    tick();
    Rom_sink_cen = 1'b0; Rom_sink_ren = 1'b0;
    load(8'd3, 16'h4444);
    tick();
    chk("esp_load_word", instrucao, 16'h3333);
    tick();
    fetch(8'd3, 16'h4444, 1'b0, 2, "esp_load_new");

    // Reset on the edge before delivery aborts the request
    Rom_sink_cen = 1'b1; Rom_sink_ren = 1'b1; endereco = 8'd5;
    tick();
    Rom_sink_cen = 1'b0; Rom_sink_ren = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    chk("abort_valida", 16'(instr_valida), 16'h0);
    chk("abort_instrucao", instrucao, 16'h0000);
    reset = 1'b1;
    tick(); tick();
    chk("abort_no_late_valida", 16'(instr_valida), 16'h0);
    chk("abort_ocupado", 16'(ocupado), 16'h0);
    fetch(8'd5, 16'h8A53, 1'b0, 2, "abort_readback");

    // Sequential fetch (fast when prefetch is built in), then non-sequential
    fetch(8'd10, 16'h0A0A, 1'b0, 2, "seq10");
    tick(); tick(); tick(); tick();
    fetch(8'd11, 16'h0B0B, 1'b0, LAT_SEQ, "seq11");
    fetch(8'd20, 16'h1414, 1'b0, 2, "jump20");
    chk("final_perdido", 16'(pedido_perdido), 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
